// File: rtl/fft_bfly_sequencer_if.sv
// Control/status bundle between the radix-2 FFT butterfly sequencer and the
// sample-RAM / twiddle-ROM / butterfly-datapath side.
interface fft_bfly_sequencer_if #(
  parameter int unsigned LOG2N = 9
);
  localparam int unsigned SW = $clog2(LOG2N);

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [SW-1:0]    stage;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );
endinterface

// File: rtl/fft_bfly_sequencer.sv
// Stage-by-stage sequencer for an in-place radix-2 DIT FFT: issues one butterfly
// per cycle, drains the datapath between stages, and delays addresses to the write port.
module fft_bfly_sequencer #(
  parameter int unsigned LOG2N        = 9,
  parameter int unsigned BFLY_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_bfly_sequencer_if.master bus
);
  localparam int unsigned AW = LOG2N;
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wr_slot_t;

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [KW-1:0] tw_idx_q, tw_idx_d;
  logic [SW-1:0] stage_q, stage_d;

  wr_slot_t      wr_pipe_q [BFLY_LATENCY];
  wr_slot_t      wr_pipe_d [BFLY_LATENCY];

  logic [AW-1:0] half, pos, grp, tw_full;
  logic [SW-1:0] tw_shift;

  always_comb begin : next_state
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (&k_q) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(BFLY_LATENCY - 1)) begin
          if (s_q == SW'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register alongside it,
  // putting the first read in the cycle right after start is sampled.
  always_comb begin : addr_gen
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    rd_en_d  = (state_d == ISSUE);
    stage_d  = (state_d == IDLE) ? '0 : s_d;

    half     = AW'(1) << s_d;
    pos      = AW'(k_d) & (half - AW'(1));
    grp      = AW'(k_d) >> s_d;
    tw_shift = SW'(LOG2N - 1) - s_d;
    tw_full  = pos << tw_shift;

    rd_addr_a_d = '0;
    rd_addr_b_d = '0;
    tw_idx_d    = '0;
    if (rd_en_d) begin
      rd_addr_a_d = ((grp << s_d) << 1) | pos;
      rd_addr_b_d = rd_addr_a_d + half;
      tw_idx_d    = tw_full[KW-1:0];
    end
  end

  always_comb begin : wr_delay
    wr_pipe_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
    for (int unsigned i = 1; i < BFLY_LATENCY; i++) begin
      wr_pipe_d[i] = wr_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_idx_q    <= '0;
      stage_q     <= '0;
      for (int unsigned i = 0; i < BFLY_LATENCY; i++) begin
        wr_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_idx_q    <= tw_idx_d;
      stage_q     <= stage_d;
      wr_pipe_q   <= wr_pipe_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_idx    = tw_idx_q;
  assign bus.stage     = stage_q;
  assign bus.wr_en     = wr_pipe_q[BFLY_LATENCY-1].en;
  assign bus.wr_addr_a = wr_pipe_q[BFLY_LATENCY-1].a;
  assign bus.wr_addr_b = wr_pipe_q[BFLY_LATENCY-1].b;
endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Directed bench for fft_bfly_sequencer: an 8-point/latency-2 instance checked
// event-by-event from a scoreboard, plus a 512-point/latency-3 full run.
module tb_fft_bfly_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst9;

  fft_bfly_sequencer_if #(.LOG2N(3)) bus3 ();
  fft_bfly_sequencer_if #(.LOG2N(9)) bus9 ();

  fft_bfly_sequencer #(.LOG2N(3), .BFLY_LATENCY(2)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  fft_bfly_sequencer #(.LOG2N(9), .BFLY_LATENCY(3)) dut9 (
    .clk (clk),
    .rst (rst9),
    .bus (bus9)
  );

  typedef struct {
    int cyc;
    int s;
    int a;
    int b;
    int tw;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  ev_t wr9_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  int wcnt [3][8];
  int last_wr [3];
  int first_rd [3];

  int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  int t9        = 0;
  int rd9_cnt   = 0;
  int wr9_cnt   = 0;
  int done9_cyc = -1;
  int done9_n   = 0;
  int done9_nxt = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic monitor3();
    ev_t e;
    int  d;
    if (bus3.rd_en === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", bus3.rd_en, 0);
      end else begin
        e = rd_q.pop_front();
        check("rd_cycle", t, e.cyc);
        check("rd_addr_a", bus3.rd_addr_a, e.a);
        check("rd_addr_b", bus3.rd_addr_b, e.b);
        check("tw_idx", bus3.tw_idx, e.tw);
        check("stage", bus3.stage, e.s);
        if (first_rd[e.s] < 0) first_rd[e.s] = t;
        if (e.s > 0) begin
          check("rd_a_after_prev_wr", wcnt[e.s-1][bus3.rd_addr_a], 1);
          check("rd_b_after_prev_wr", wcnt[e.s-1][bus3.rd_addr_b], 1);
        end
      end
    end else if (rd_q.size() != 0 && rd_q[0].cyc <= t) begin
      check("rd_missing", bus3.rd_en, 1);
      void'(rd_q.pop_front());
    end

    if (bus3.wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", bus3.wr_en, 0);
      end else begin
        e = wr_q.pop_front();
        check("wr_cycle", t, e.cyc);
        check("wr_addr_a", bus3.wr_addr_a, e.a);
        check("wr_addr_b", bus3.wr_addr_b, e.b);
        wcnt[e.s][bus3.wr_addr_a]++;
        wcnt[e.s][bus3.wr_addr_b]++;
        last_wr[e.s] = t;
      end
    end else if (wr_q.size() != 0 && wr_q[0].cyc <= t) begin
      check("wr_missing", bus3.wr_en, 1);
      void'(wr_q.pop_front());
    end

    if (bus3.done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", bus3.done, 0);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", t, d);
        check("done_stage", bus3.stage, 2);
      end
    end else if (done_q.size() != 0 && done_q[0] <= t) begin
      check("done_missing", bus3.done, 1);
      void'(done_q.pop_front());
    end

    check("busy", bus3.busy, (t >= busy_lo && t <= busy_hi) ? 1 : 0);
    if (!(t >= busy_lo && t <= busy_hi)) check("stage_idle", bus3.stage, 0);
  endtask

  task automatic monitor9();
    int  s, k, half, pos, grp, ea;
    ev_t e;
    if (bus9.rd_en === 1'b1) begin
      if (rd9_cnt >= 2304) begin
        check("rd9_extra", bus9.rd_en, 0);
      end else begin
        s    = rd9_cnt / 256;
        k    = rd9_cnt % 256;
        half = 1 << s;
        pos  = k % half;
        grp  = k / half;
        ea   = grp * 2 * half + pos;
        check("rd9_cycle", t, t9 + 1 + s * 259 + k);
        check("rd9_addr_a", bus9.rd_addr_a, ea);
        check("rd9_addr_b", bus9.rd_addr_b, ea + half);
        check("rd9_tw", bus9.tw_idx, pos << (8 - s));
        e.cyc = t + 3; e.s = s; e.a = ea; e.b = ea + half; e.tw = 0;
        wr9_q.push_back(e);
      end
      rd9_cnt++;
    end
    if (bus9.wr_en === 1'b1) begin
      wr9_cnt++;
      if (wr9_q.size() == 0) begin
        check("wr9_unexpected", bus9.wr_en, 0);
      end else begin
        e = wr9_q.pop_front();
        check("wr9_cycle", t, e.cyc);
        check("wr9_addr_a", bus9.wr_addr_a, e.a);
        check("wr9_addr_b", bus9.wr_addr_b, e.b);
      end
    end
    if (t == done9_nxt) check("busy9_after_done", bus9.busy, 0);
    if (bus9.done === 1'b1) begin
      done9_n++;
      if (done9_cyc < 0) done9_cyc = t;
      done9_nxt = t + 1;
      check("busy9_at_done", bus9.busy, 1);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    t++;
    monitor3();
    monitor9();
  endtask

  task automatic run_to(input int target);
    while (t < target) next_cycle();
  endtask

  // Queue a complete expected run of the 8-point instance with start sampled this cycle.
  task automatic launch3(output int t0);
    ev_t e;
    t0 = t;
    bus3.start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e.s   = i / 4;
      e.cyc = t0 + 1 + e.s * 6 + (i % 4);
      e.a   = exp_a[i];
      e.b   = exp_b[i];
      e.tw  = exp_tw[i];
      rd_q.push_back(e);
      e.cyc = e.cyc + 2;
      wr_q.push_back(e);
    end
    done_q.push_back(t0 + 19);
    busy_lo = t0 + 1;
    busy_hi = t0 + 19;
    for (int s = 0; s < 3; s++) begin
      last_wr[s]  = -1;
      first_rd[s] = -1;
      for (int a = 0; a < 8; a++) wcnt[s][a] = 0;
    end
  endtask

  task automatic flush3(input int tr);
    ev_t keep_rd[$];
    ev_t keep_wr[$];
    foreach (rd_q[i]) if (rd_q[i].cyc <= tr) keep_rd.push_back(rd_q[i]);
    foreach (wr_q[i]) if (wr_q[i].cyc <= tr) keep_wr.push_back(wr_q[i]);
    rd_q = keep_rd;
    wr_q = keep_wr;
    done_q.delete();
    busy_hi = tr;
  endtask

  task automatic check_run3();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("hazard_s%0d", s), (last_wr[s] < first_rd[s+1]) ? 1 : 0, 1);
    end
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 8; a++) begin
        check($sformatf("write_once_s%0d_a%0d", s, a), wcnt[s][a], 1);
      end
    end
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
  endtask

  initial begin
    int t0, t1, t2;
    rst3 = 1'b1;
    rst9 = 1'b1;
    bus3.start = 1'b0;
    bus9.start = 1'b0;
    repeat (3) next_cycle();
    rst3 = 1'b0;
    rst9 = 1'b0;

    check("rst_busy", bus3.busy, 0);
    check("rst_done", bus3.done, 0);
    check("rst_rd_en", bus3.rd_en, 0);
    check("rst_wr_en", bus3.wr_en, 0);
    check("rst_rd_addr_a", bus3.rd_addr_a, 0);
    check("rst_wr_addr_b", bus3.wr_addr_b, 0);
    check("rst_tw_idx", bus3.tw_idx, 0);
    check("rst_stage", bus3.stage, 0);
    check("rst9_busy", bus9.busy, 0);
    check("rst9_wr_en", bus9.wr_en, 0);
    repeat (2) next_cycle();

    // Full run with stray start pulses at relative cycles 5 and 19.
    launch3(t0);
    next_cycle();
    bus3.start = 1'b0;
    run_to(t0 + 5);
    bus3.start = 1'b1;
    next_cycle();
    bus3.start = 1'b0;
    run_to(t0 + 19);
    bus3.start = 1'b1;
    next_cycle();
    bus3.start = 1'b0;
    run_to(t0 + 21);
    check_run3();

    // Relaunch at cycle 21, then reset it at relative cycle 9.
    launch3(t1);
    check("relaunch_offset", t1 - t0, 21);
    next_cycle();
    bus3.start = 1'b0;
    run_to(t1 + 9);
    rst3 = 1'b1;
    flush3(t);
    next_cycle();
    check("midrst_busy", bus3.busy, 0);
    check("midrst_done", bus3.done, 0);
    check("midrst_rd_en", bus3.rd_en, 0);
    check("midrst_wr_en", bus3.wr_en, 0);
    check("midrst_rd_addr_a", bus3.rd_addr_a, 0);
    check("midrst_rd_addr_b", bus3.rd_addr_b, 0);
    check("midrst_wr_addr_a", bus3.wr_addr_a, 0);
    check("midrst_tw_idx", bus3.tw_idx, 0);
    check("midrst_stage", bus3.stage, 0);
    rst3 = 1'b0;
    next_cycle();

    launch3(t2);
    next_cycle();
    bus3.start = 1'b0;
    run_to(t2 + 24);
    check_run3();

    // 512-point, latency-3 full run.
    t9 = t;
    bus9.start = 1'b1;
    next_cycle();
    bus9.start = 1'b0;
    check("busy9_first", bus9.busy, 1);
    for (int i = 0; i < 2400 && done9_cyc < 0; i++) next_cycle();
    repeat (3) next_cycle();
    check("rd9_count", rd9_cnt, 2304);
    check("wr9_count", wr9_cnt, 2304);
    check("done9_cycle", done9_cyc - t9, 2332);
    check("done9_pulses", done9_n, 1);
    check("wr9_q_drained", wr9_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
